// File: rtl/ex_mem_reg_pkg.sv
// Shared MIPS pipeline encodings: writeback selects, forward-select codes, NOP word.
// Also holds the saturating Tnew decrement used at every stage boundary.
package mips_defs;

  localparam logic [1:0] WDSEL_ALU = 2'b00;
  localparam logic [1:0] WDSEL_MEM = 2'b01;
  localparam logic [1:0] WDSEL_PC8 = 2'b10;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_ALU_M = 2'b01;
  localparam logic [1:0] FWD_PC8_M = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  // Result readiness counts down one per stage and parks at zero.
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// E-stage inputs and M-stage outputs of the E/M pipeline register.
// The slave side is the register itself; the master side drives E and observes M.
interface ex_mem_reg_if #(parameter int WIDTH = 32);

  logic [WIDTH-1:0] Instr_E;
  logic [WIDTH-1:0] pc_E;
  logic [WIDTH-1:0] ALU_O_E;
  logic [WIDTH-1:0] WD_E;
  logic [4:0]       A3_E;
  logic             RegWrite_E;
  logic             MemWrite_E;
  logic [1:0]       WDSel_E;
  logic [1:0]       Tnew_E;

  logic [WIDTH-1:0] Instr_M;
  logic [WIDTH-1:0] pc8_M;
  logic [WIDTH-1:0] ALU_O_M;
  logic [WIDTH-1:0] WD_M;
  logic [4:0]       A3_M;
  logic             RegWrite_M;
  logic             MemWrite_M;
  logic [1:0]       WDSel_M;
  logic [1:0]       Tnew_M;
  logic [1:0]       FwdSel_M;
  logic             valid_M;

  modport slave (
    input  Instr_E, pc_E, ALU_O_E, WD_E, A3_E, RegWrite_E, MemWrite_E, WDSel_E, Tnew_E,
    output Instr_M, pc8_M, ALU_O_M, WD_M, A3_M, RegWrite_M, MemWrite_M, WDSel_M, Tnew_M,
           FwdSel_M, valid_M
  );

  modport master (
    output Instr_E, pc_E, ALU_O_E, WD_E, A3_E, RegWrite_E, MemWrite_E, WDSel_E, Tnew_E,
    input  Instr_M, pc8_M, ALU_O_M, WD_M, A3_M, RegWrite_M, MemWrite_M, WDSel_M, Tnew_M,
           FwdSel_M, valid_M
  );

endinterface

// File: rtl/ex_mem_reg_pipe_reg_en_clr.sv
// Generic pipeline register: async active-low reset, enable, synchronous clear.
// Enable dominates clear, so a held stage ignores a concurrent flush.
module pipe_reg_en_clr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// E/M pipeline register: captures Execute results for Memory, and derives the
// M-stage forwarding source plus a saturating count of bubbles loaded.
module ex_mem_reg
  import mips_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_M,
  input  logic             flush_E,
  ex_mem_reg_if.slave      bus,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int DATA_W = 4 * WIDTH;
  localparam int CTRL_W = 12;

  logic              en;
  logic              reg_write_d;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_d;
  logic [CTRL_W-1:0] ctrl_q;
  logic [1:0]        fwd_sel;

  assign en          = !stall_M;
  // Writes to $0 are dropped here so downstream forwarding never sees them.
  assign reg_write_d = bus.RegWrite_E && (bus.A3_E != 5'd0);

  assign data_d = {bus.Instr_E, bus.pc_E + WIDTH'(8), bus.ALU_O_E, bus.WD_E};
  assign ctrl_d = {bus.A3_E, reg_write_d, bus.MemWrite_E, bus.WDSel_E,
                   tnew_dec(bus.Tnew_E), 1'b1};

  pipe_reg_en_clr #(.WIDTH(DATA_W)) u_data (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (flush_E),
    .d     (data_d),
    .q     (data_q)
  );

  pipe_reg_en_clr #(.WIDTH(CTRL_W)) u_ctrl (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (flush_E),
    .d     (ctrl_d),
    .q     (ctrl_q)
  );

  assign {bus.Instr_M, bus.pc8_M, bus.ALU_O_M, bus.WD_M} = data_q;
  assign {bus.A3_M, bus.RegWrite_M, bus.MemWrite_M, bus.WDSel_M,
          bus.Tnew_M, bus.valid_M} = ctrl_q;

  // Load data is not ready until W, so only ALU and link results forward from M.
  always_comb begin
    fwd_sel = FWD_RF;
    if (bus.RegWrite_M) begin
      case (bus.WDSel_M)
        WDSEL_ALU: fwd_sel = FWD_ALU_M;
        WDSEL_PC8: fwd_sel = FWD_PC8_M;
        WDSEL_MEM: fwd_sel = FWD_RF;
        default:   fwd_sel = FWD_RF;
      endcase
    end
  end

  assign bus.FwdSel_M = fwd_sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (!stall_M && flush_E && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: vector table through a scoreboard queue,
// plus async reset, reset release and small-counter saturation sequences.
module tb_ex_mem_reg;
  import mips_defs::*;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  a3;
    logic        rw;
    logic        mw;
    logic [1:0]  wdsel;
    logic [1:0]  tnew;
  } in_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  a3;
    logic        rw;
    logic        mw;
    logic [1:0]  wdsel;
    logic [1:0]  tnew;
    logic [1:0]  fwd;
    logic        valid;
    logic [15:0] bub;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        stall_M;
  logic        flush_E;
  logic        stall2;
  logic        flush2;
  logic [15:0] bubble_cnt;
  logic [1:0]  bubble_cnt2;

  int n_vec;
  int n_err;

  out_t q_exp[$];
  vec_t vecs[14];

  ex_mem_reg_if #(.WIDTH(32)) bus ();
  ex_mem_reg_if #(.WIDTH(32)) bus2 ();

  ex_mem_reg #(.WIDTH(32), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall_M    (stall_M),
    .flush_E    (flush_E),
    .bus        (bus),
    .bubble_cnt (bubble_cnt)
  );

  ex_mem_reg #(.WIDTH(32), .CNT_W(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .stall_M    (stall2),
    .flush_E    (flush2),
    .bus        (bus2),
    .bubble_cnt (bubble_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t get_out();
    out_t o;
    o.instr = bus.Instr_M;
    o.pc8   = bus.pc8_M;
    o.alu   = bus.ALU_O_M;
    o.wd    = bus.WD_M;
    o.a3    = bus.A3_M;
    o.rw    = bus.RegWrite_M;
    o.mw    = bus.MemWrite_M;
    o.wdsel = bus.WDSel_M;
    o.tnew  = bus.Tnew_M;
    o.fwd   = bus.FwdSel_M;
    o.valid = bus.valid_M;
    o.bub   = bubble_cnt;
    return o;
  endfunction

  task automatic drive(input in_t i);
    stall_M        = i.stall;
    flush_E        = i.flush;
    bus.Instr_E    = i.instr;
    bus.pc_E       = i.pc;
    bus.ALU_O_E    = i.alu;
    bus.WD_E       = i.wd;
    bus.A3_E       = i.a3;
    bus.RegWrite_E = i.rw;
    bus.MemWrite_E = i.mw;
    bus.WDSel_E    = i.wdsel;
    bus.Tnew_E     = i.tnew;
  endtask

  task automatic check(input string name, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  initial begin
    out_t zero_o;
    out_t addu_o;
    in_t  addu_i;
    out_t exp_o;

    n_vec = 0;
    n_err = 0;

    addu_i = '{1'b0, 1'b0, 32'h01095021, 32'h00003000, 32'h00001234, 32'h0000AAAA,
               5'd8, 1'b1, 1'b0, 2'b00, 2'd1};
    addu_o = '{32'h01095021, 32'h00003008, 32'h00001234, 32'h0000AAAA,
               5'd8, 1'b1, 1'b0, 2'b00, 2'd0, 2'b01, 1'b1, 16'd0};
    zero_o = '{NOP_INSTR, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 2'd0, 2'b00, 1'b0, 16'd0};

    vecs[0].i = addu_i;
    vecs[0].e = addu_o;
    vecs[1].i = '{1'b0, 1'b0, 32'h0C000100, 32'hFFFFFFFC, 32'h0, 32'h0, 5'd31, 1'b1, 1'b0, 2'b10, 2'd0};
    vecs[1].e = '{32'h0C000100, 32'h00000004, 32'h0, 32'h0, 5'd31, 1'b1, 1'b0, 2'b10, 2'd0, 2'b10, 1'b1, 16'd0};
    vecs[2].i = '{1'b0, 1'b0, 32'h8D090004, 32'h00003010, 32'h00002004, 32'h55, 5'd9, 1'b1, 1'b0, 2'b01, 2'd2};
    vecs[2].e = '{32'h8D090004, 32'h00003018, 32'h00002004, 32'h55, 5'd9, 1'b1, 1'b0, 2'b01, 2'd1, 2'b00, 1'b1, 16'd0};
    vecs[3].i = '{1'b0, 1'b0, 32'h00004021, 32'h00003020, 32'h77, 32'h0, 5'd0, 1'b1, 1'b0, 2'b00, 2'd1};
    vecs[3].e = '{32'h00004021, 32'h00003028, 32'h77, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 2'd0, 2'b00, 1'b1, 16'd0};
    vecs[4].i = '{1'b0, 1'b0, 32'hAD0A0008, 32'h00003030, 32'h100, 32'hDEADBEEF, 5'd5, 1'b0, 1'b1, 2'b00, 2'd0};
    vecs[4].e = '{32'hAD0A0008, 32'h00003038, 32'h100, 32'hDEADBEEF, 5'd5, 1'b0, 1'b1, 2'b00, 2'd0, 2'b00, 1'b1, 16'd0};
    vecs[5].i = '{1'b0, 1'b0, 32'h12345678, 32'h00003040, 32'h9, 32'h8, 5'd3, 1'b1, 1'b0, 2'b11, 2'd3};
    vecs[5].e = '{32'h12345678, 32'h00003048, 32'h9, 32'h8, 5'd3, 1'b1, 1'b0, 2'b11, 2'd2, 2'b00, 1'b1, 16'd0};
    vecs[6].i = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'h00005000, 32'hFFFF, 32'h1, 5'd7, 1'b1, 1'b1, 2'b10, 2'd3};
    vecs[6].e = zero_o;
    vecs[6].e.bub = 16'd1;
    vecs[7].i = '{1'b0, 1'b1, 32'hA5A5A5A5, 32'h00005004, 32'h5A5A, 32'h2, 5'd12, 1'b1, 1'b0, 2'b00, 2'd1};
    vecs[7].e = zero_o;
    vecs[7].e.bub = 16'd2;
    vecs[8].i = '{1'b0, 1'b1, 32'h11111111, 32'h00005008, 32'h3, 32'h4, 5'd1, 1'b1, 1'b1, 2'b01, 2'd2};
    vecs[8].e = zero_o;
    vecs[8].e.bub = 16'd3;
    vecs[9].i = addu_i;
    vecs[9].e = addu_o;
    vecs[9].e.bub = 16'd3;
    vecs[10].i = '{1'b1, 1'b1, 32'hCAFEF00D, 32'h00006000, 32'hBEEF, 32'h9, 5'd20, 1'b1, 1'b1, 2'b10, 2'd2};
    vecs[10].e = vecs[9].e;
    vecs[11].i = '{1'b1, 1'b0, 32'h0C000200, 32'h00007000, 32'h1, 32'h2, 5'd31, 1'b1, 1'b0, 2'b10, 2'd0};
    vecs[11].e = vecs[9].e;
    vecs[12].i = '{1'b0, 1'b1, 32'h0C000200, 32'h00007000, 32'h1, 32'h2, 5'd31, 1'b1, 1'b0, 2'b10, 2'd0};
    vecs[12].e = zero_o;
    vecs[12].e.bub = 16'd4;
    vecs[13].i = '{1'b0, 1'b0, 32'h03E00008, 32'h00000010, 32'h44, 32'h0, 5'd2, 1'b1, 1'b0, 2'b10, 2'd2};
    vecs[13].e = '{32'h03E00008, 32'h00000018, 32'h44, 32'h0, 5'd2, 1'b1, 1'b0, 2'b10, 2'd1, 2'b10, 1'b1, 16'd4};

    reset  = 1'b0;
    stall2 = 1'b0;
    flush2 = 1'b0;
    drive('0);
    bus2.Instr_E    = '0;
    bus2.pc_E       = '0;
    bus2.ALU_O_E    = '0;
    bus2.WD_E       = '0;
    bus2.A3_E       = '0;
    bus2.RegWrite_E = 1'b0;
    bus2.MemWrite_E = 1'b0;
    bus2.WDSel_E    = '0;
    bus2.Tnew_E     = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", get_out(), zero_o);

    @(negedge clk);
    reset = 1'b1;

    for (int k = 0; k < 14; k++) begin
      drive(vecs[k].i);
      q_exp.push_back(vecs[k].e);
      @(posedge clk);
      #1;
      exp_o = q_exp.pop_front();
      check($sformatf("vec%0d", k), get_out(), exp_o);
      @(negedge clk);
    end

    // Async reset mid-run, observed before any clock edge.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async_reset_immediate", get_out(), zero_o);
    @(posedge clk);
    #1;
    check("async_reset_hold", get_out(), zero_o);

    // First edge after release performs a normal load.
    @(negedge clk);
    reset = 1'b1;
    drive(addu_i);
    q_exp.push_back(addu_o);
    @(posedge clk);
    #1;
    exp_o = q_exp.pop_front();
    check("reset_release_load", get_out(), exp_o);

    // Two-bit bubble counter saturates at 3.
    @(negedge clk);
    flush2 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check_cnt($sformatf("cnt2_flush%0d", k), bubble_cnt2, (k < 3) ? 2'(k) : 2'd3);
    end
    @(negedge clk);
    flush2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
